// File: rtl/standby_bus_arbiter.sv
`default_nettype none
// ============================================================================
// standby_bus_arbiter: hands the shared SCL/SDA pair to one standby engine,
// switching owner only while the bus is free.    Revision 1.0
// ============================================================================
module standby_bus_arbiter #(
    parameter int IdleCntWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    i2c_standby_en_i,
    input  logic                    i3c_standby_en_i,
    input  logic [IdleCntWidth-1:0] bus_idle_cycles_i,
    input  logic                    bus_scl_i,
    input  logic                    bus_sda_i,
    output logic                    bus_scl_o,
    output logic                    bus_sda_o,
    output logic                    i2c_scl_o,
    output logic                    i2c_sda_o,
    input  logic                    i2c_scl_drv_i,
    input  logic                    i2c_sda_drv_i,
    output logic                    i3c_scl_o,
    output logic                    i3c_sda_o,
    input  logic                    i3c_scl_drv_i,
    input  logic                    i3c_sda_drv_i,
    output logic [1:0]              sel_o,
    output logic                    switch_pending_o,
    output logic                    bus_busy_o
);

    // Owner states share their encoding with sel_o so SWITCH can return directly.
    localparam logic [1:0] ST_NONE   = 2'd0;
    localparam logic [1:0] ST_I2C    = 2'd1;
    localparam logic [1:0] ST_I3C    = 2'd2;
    localparam logic [1:0] ST_SWITCH = 2'd3;

    logic [1:0]              state;
    logic [1:0]              sel;
    logic [1:0]              req;
    logic                    scl_q;
    logic                    sda_q;
    logic                    busy;
    logic [IdleCntWidth-1:0] idle_cnt;
    logic                    lines_high;
    logic                    start_cond;
    logic                    stop_cond;
    logic                    bus_free;

    always_comb begin
        req = ST_NONE;
        if (i3c_standby_en_i) begin
            req = ST_I3C;
        end else if (i2c_standby_en_i) begin
            req = ST_I2C;
        end
    end

    assign lines_high = bus_scl_i & bus_sda_i;
    assign start_cond = scl_q & bus_scl_i & sda_q & ~bus_sda_i;
    assign stop_cond  = scl_q & bus_scl_i & ~sda_q & bus_sda_i;
    assign bus_free   = ~busy & lines_high & (idle_cnt >= bus_idle_cycles_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            busy     <= 1'b0;
            idle_cnt <= '0;
        end else begin
            scl_q <= bus_scl_i;
            sda_q <= bus_sda_i;
            if (start_cond) begin
                busy <= 1'b1;
            end else if (stop_cond) begin
                busy <= 1'b0;
            end
            if (!lines_high || start_cond) begin
                idle_cnt <= '0;
            end else if (idle_cnt != {IdleCntWidth{1'b1}}) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_NONE;
            sel   <= ST_NONE;
        end else begin
            case (state)
                ST_SWITCH: begin
                    if (req == sel) begin
                        state <= sel;
                    end else if (bus_free) begin
                        sel   <= req;
                        state <= req;
                    end
                end
                default: begin
                    if (req != state) begin
                        state <= ST_SWITCH;
                    end
                end
            endcase
        end
    end

    // The unselected engine sees a released (idle) bus.
    always_comb begin
        bus_scl_o = 1'b1;
        bus_sda_o = 1'b1;
        i2c_scl_o = 1'b1;
        i2c_sda_o = 1'b1;
        i3c_scl_o = 1'b1;
        i3c_sda_o = 1'b1;
        case (sel)
            ST_I2C: begin
                bus_scl_o = i2c_scl_drv_i;
                bus_sda_o = i2c_sda_drv_i;
                i2c_scl_o = bus_scl_i;
                i2c_sda_o = bus_sda_i;
            end
            ST_I3C: begin
                bus_scl_o = i3c_scl_drv_i;
                bus_sda_o = i3c_sda_drv_i;
                i3c_scl_o = bus_scl_i;
                i3c_sda_o = bus_sda_i;
            end
            default: ;
        endcase
    end

    assign sel_o            = sel;
    assign switch_pending_o = (state == ST_SWITCH);
    assign bus_busy_o       = busy;

endmodule
`default_nettype wire

// File: tb/tb_standby_bus_arbiter.sv
`default_nettype none
// Randomized and directed bench for standby_bus_arbiter against a rule-level model.
module tb_standby_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        i2c_en = 1'b0;
    logic        i3c_en = 1'b0;
    logic [15:0] thr = 16'd4;
    logic        scl = 1'b1;
    logic        sda = 1'b1;
    logic        i2c_scl_drv = 1'b1;
    logic        i2c_sda_drv = 1'b1;
    logic        i3c_scl_drv = 1'b1;
    logic        i3c_sda_drv = 1'b1;
    logic        bus_scl_o, bus_sda_o, i2c_scl_o, i2c_sda_o, i3c_scl_o, i3c_sda_o;
    logic [1:0]  sel_o;
    logic        switch_pending_o, bus_busy_o;

    int n_checks = 0;
    int n_err = 0;

    standby_bus_arbiter #(.IdleCntWidth(16)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .i2c_standby_en_i(i2c_en), .i3c_standby_en_i(i3c_en),
        .bus_idle_cycles_i(thr),
        .bus_scl_i(scl), .bus_sda_i(sda),
        .bus_scl_o(bus_scl_o), .bus_sda_o(bus_sda_o),
        .i2c_scl_o(i2c_scl_o), .i2c_sda_o(i2c_sda_o),
        .i2c_scl_drv_i(i2c_scl_drv), .i2c_sda_drv_i(i2c_sda_drv),
        .i3c_scl_o(i3c_scl_o), .i3c_sda_o(i3c_sda_o),
        .i3c_scl_drv_i(i3c_scl_drv), .i3c_sda_drv_i(i3c_sda_drv),
        .sel_o(sel_o), .switch_pending_o(switch_pending_o), .bus_busy_o(bus_busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_owner = 0;
    bit m_pending = 0;
    bit m_busy = 0;
    int m_cnt = 0;
    bit m_pscl = 1, m_psda = 1;

    initial begin
        forever begin
            @(posedge clk or negedge rst_ni);
            if (!rst_ni) begin
                m_owner = 0; m_pending = 0; m_busy = 0; m_cnt = 0; m_pscl = 1; m_psda = 1;
            end else begin
                int  req;
                bit  both, st, sp, fr;
                req  = i3c_en ? 2 : (i2c_en ? 1 : 0);
                both = scl && sda;
                st   = m_pscl && scl && m_psda && !sda;
                sp   = m_pscl && scl && !m_psda && sda;
                fr   = !m_busy && both && (m_cnt >= int'(thr));
                if (!m_pending) begin
                    if (req != m_owner) m_pending = 1;
                end else if (req == m_owner) begin
                    m_pending = 0;
                end else if (fr) begin
                    m_owner = req;
                    m_pending = 0;
                end
                if (st) m_busy = 1;
                else if (sp) m_busy = 0;
                if (!both || st) m_cnt = 0;
                else if (m_cnt < 65535) m_cnt = m_cnt + 1;
                m_pscl = scl;
                m_psda = sda;
            end
        end
    end

    // Per-cycle comparison, sampled mid low phase after inputs have settled.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_ni) begin
                int e_bscl, e_bsda, e_2scl, e_2sda, e_3scl, e_3sda;
                e_bscl = 1; e_bsda = 1; e_2scl = 1; e_2sda = 1; e_3scl = 1; e_3sda = 1;
                if (m_owner == 1) begin
                    e_bscl = i2c_scl_drv; e_bsda = i2c_sda_drv; e_2scl = scl; e_2sda = sda;
                end else if (m_owner == 2) begin
                    e_bscl = i3c_scl_drv; e_bsda = i3c_sda_drv; e_3scl = scl; e_3sda = sda;
                end
                check("model_sel", sel_o, m_owner);
                check("model_pending", switch_pending_o, m_pending);
                check("model_busy", bus_busy_o, m_busy);
                check("model_bus_scl", bus_scl_o, e_bscl);
                check("model_bus_sda", bus_sda_o, e_bsda);
                check("model_i2c_lines", {i2c_scl_o, i2c_sda_o}, {e_2scl[0], e_2sda[0]});
                check("model_i3c_lines", {i3c_scl_o, i3c_sda_o}, {e_3scl[0], e_3sda[0]});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic smp();
        #4;
    endtask

    task automatic set_lines(input logic s, input logic d);
        step();
        scl = s;
        sda = d;
    endtask

    task automatic bus_start();
        set_lines(1, 1);
        set_lines(1, 0);
        set_lines(0, 0);
    endtask

    task automatic bus_stop();
        set_lines(0, 0);
        set_lines(1, 0);
        set_lines(1, 1);
    endtask

    task automatic data_bits(input int n);
        for (int i = 0; i < n; i++) begin
            logic b;
            b = 1'($urandom_range(0, 1));
            set_lines(0, b);
            set_lines(1, b);
        end
        set_lines(0, sda);
    endtask

    task automatic wait_sel(input int v, input string name);
        int i;
        i = 0;
        step();
        smp();
        while (int'(sel_o) != v && i < 40) begin
            step();
            smp();
            i++;
        end
        check(name, sel_o, v);
    endtask

    task automatic check_all_idle(input string name);
        check(name, {bus_scl_o, bus_sda_o, i2c_scl_o, i2c_sda_o, i3c_scl_o, i3c_sda_o}, 6'b111111);
        check({name, "_sel"}, sel_o, 0);
        check({name, "_pend_busy"}, {switch_pending_o, bus_busy_o}, 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int pend_cnt, first_sel;

        // Reset values, then I2C enable with threshold 4.
        step();
        smp();
        check_all_idle("reset_state");
        step();
        rst_ni = 1'b1;
        i2c_en = 1'b1;
        pend_cnt = 0;
        first_sel = -1;
        for (int k = 0; k < 10; k++) begin
            smp();
            if (switch_pending_o) pend_cnt++;
            if (first_sel < 0 && sel_o == 2'd1) first_sel = k;
            step();
        end
        check("enable_pending_cycles", pend_cnt, 4);
        check("enable_first_sel_cycle", first_sel, 5);
        i2c_scl_drv = 1'b0;
        smp();
        check("passthru_bus_scl", bus_scl_o, 0);
        check("passthru_i3c_idle", {i3c_scl_o, i3c_sda_o}, 2'b11);
        step();
        i2c_scl_drv = 1'b1;

        // Switch requested mid-transaction waits for STOP plus idle time.
        bus_start();
        data_bits(3);
        step();
        i3c_en = 1'b1;
        data_bits(4);
        smp();
        check("midxfer_sel_held", sel_o, 1);
        check("midxfer_pending", switch_pending_o, 1);
        check("midxfer_busy", bus_busy_o, 1);
        bus_stop();
        wait_sel(2, "handover_to_i3c");
        check("i2c_lines_parked", {i2c_scl_o, i2c_sda_o}, 2'b11);

        // Back to I2C, then a withdrawn request during a busy bus.
        step();
        i3c_en = 1'b0;
        wait_sel(1, "back_to_i2c");
        bus_start();
        data_bits(2);
        step();
        i3c_en = 1'b1;
        step();
        step();
        smp();
        check("withdraw_pending", switch_pending_o, 1);
        step();
        i3c_en = 1'b0;
        step();
        smp();
        check("withdraw_returned", {sel_o, switch_pending_o}, 3'b010);
        bus_stop();

        // Repeated START keeps busy through to STOP.
        bus_start();
        data_bits(1);
        set_lines(0, 1);
        set_lines(1, 1);
        set_lines(1, 0);
        smp();
        check("rstart_busy", bus_busy_o, 1);
        data_bits(2);
        set_lines(0, 0);
        set_lines(1, 0);
        set_lines(1, 1);
        smp();
        check("stop_cycle_busy", bus_busy_o, 1);
        step();
        smp();
        check("after_stop_busy", bus_busy_o, 0);

        // Threshold 0: handover one cycle after entering SWITCH.
        thr = 16'd0;
        step();
        step();
        i3c_en = 1'b1;
        smp();
        check("thr0_not_yet", switch_pending_o, 0);
        step();
        smp();
        check("thr0_pending", {sel_o, switch_pending_o}, 3'b011);
        step();
        smp();
        check("thr0_switched", {sel_o, switch_pending_o}, 3'b100);

        // Counter saturation: after 70000 high cycles the max threshold is met.
        thr = 16'hFFFF;
        repeat (70000) step();
        i3c_en = 1'b0;
        step();
        smp();
        check("sat_pending", switch_pending_o, 1);
        step();
        smp();
        check("sat_switched", sel_o, 1);
        thr = 16'd4;

        // Asynchronous reset mid-transfer with I3C selected.
        step();
        i3c_en = 1'b1;
        wait_sel(2, "pre_reset_i3c");
        bus_start();
        i3c_scl_drv = 1'b0;
        data_bits(2);
        @(negedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        check_all_idle("async_reset");
        step();
        i3c_scl_drv = 1'b1;
        scl = 1'b1;
        sda = 1'b1;
        step();
        rst_ni = 1'b1;

        // Randomized traffic.
        begin
            int quiet;
            quiet = 0;
            for (int c = 0; c < 4000; c++) begin
                step();
                if ($urandom_range(0, 99) < 3) i2c_en = ~i2c_en;
                if ($urandom_range(0, 99) < 3) i3c_en = ~i3c_en;
                if ((c % 250) == 0) thr = 16'($urandom_range(0, 6));
                i2c_scl_drv = 1'($urandom_range(0, 1));
                i2c_sda_drv = 1'($urandom_range(0, 1));
                i3c_scl_drv = 1'($urandom_range(0, 1));
                i3c_sda_drv = 1'($urandom_range(0, 1));
                if (quiet > 0) begin
                    scl = 1'b1;
                    sda = 1'b1;
                    quiet--;
                end else begin
                    if ($urandom_range(0, 2) == 0) scl = ~scl;
                    if ($urandom_range(0, 3) == 0) sda = ~sda;
                    if ($urandom_range(0, 19) == 0) quiet = $urandom_range(0, 12);
                end
            end
        end

        step();
        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
